// File: rtl/riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit
//
// Instruction-fetch front end. Walks a PC through a synchronous-read
// instruction memory one word per cycle and parks the returned words in a
// two-entry FIFO. Decode drains the FIFO over a valid/ready handshake. A
// taken branch or jump redirects the PC and throws away everything fetched
// down the old path, both the buffered words and the word still in flight.
//
// Ports
//   CLK            system clock, rising edge
//   RST            asynchronous, active-high reset
//   imem_req       fetch request this cycle
//   imem_addr      fetch address (current PC); also the top-level ADDR port
//   imem_rdata     instruction word, valid the cycle after an issued request
//   redirect_valid single-cycle redirect pulse, overrides everything else
//   redirect_pc    redirect target (low two bits ignored)
//   out_valid      FIFO head available to decode
//   out_ready      decode accepts the head this cycle
//   out_instr      FIFO head instruction
//   out_pc         PC of out_instr
// -----------------------------------------------------------------------------
module riscv_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              RST,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   // One buffered fetch: the instruction together with the PC it came from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fifo_entry_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   // Fetch state
   logic [ADDR_W-1:0] pc;
   logic              inflight;      // a request was issued last cycle
   logic [ADDR_W-1:0] inflight_pc;   // address of that request

   // Two-entry FIFO
   fifo_entry_t       fifo_mem [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        fifo_count;

   logic              fifo_push;
   logic              fifo_pop;
   logic [2:0]        occupancy;
   logic [ADDR_W-1:0] redirect_target;

   // --------------------------------------------------------------------------
   // Handshake, issue and push decisions
   // --------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb block gets a value on every
   // path (here: one unconditional assignment each), so no latch is inferred.
   always_comb begin
      // A redirect squashes the handshake in its own cycle so that decode
      // never consumes a word from the path being abandoned.
      out_valid = (fifo_count != 2'd0) && !redirect_valid;
      fifo_pop  = out_valid && out_ready;

      // The response to last cycle's request is kept unless a redirect
      // makes it stale.
      fifo_push = inflight && !redirect_valid;

      // Words buffered plus the word on its way back. Issue only when, after
      // this cycle's pop, there is still room for the new word: the
      // inequality below is "occupancy - pop < 2" rearranged to avoid an
      // unsigned underflow.
      occupancy = {1'b0, fifo_count} + {2'b00, inflight};
      imem_req  = !RST && !redirect_valid && (occupancy < (3'd2 + {2'b00, fifo_pop}));

      imem_addr = pc;
      out_pc    = fifo_mem[rd_ptr].pc;
      out_instr = fifo_mem[rd_ptr].instr;

      // Instructions are word aligned; the low bits of a target are dropped.
      redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
   end

   // --------------------------------------------------------------------------
   // PC and in-flight tracking
   // --------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect_valid) begin
         pc          <= redirect_target;
         inflight    <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= pc;
            pc          <= pc + PC_STEP;   // wraps modulo 2^ADDR_W
         end
      end
   end

   // --------------------------------------------------------------------------
   // FIFO pointers and occupancy
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else if (redirect_valid) begin
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (fifo_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         // Simultaneous push and pop leave the count unchanged. A pop only
         // happens when out_valid is high, so an empty FIFO is never popped.
         unique case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // FIFO storage
   // --------------------------------------------------------------------------
   // NOTE: storage arrays are normally left unreset; these two entries are
   // cleared because out_instr/out_pc read straight from the head entry and
   // must show zero coming out of reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 2; i++) begin
            fifo_mem[i] <= '0;
         end
      end else if (fifo_push) begin
         fifo_mem[wr_ptr] <= '{pc: inflight_pc, instr: imem_rdata};
      end
   end

endmodule
